apb_uart_tx: RTL and testbench

APB_UART_TX -- requirements
Module: apb_uart_tx

---
 rtl/apb_uart_tx.sv | 133 +++++++++++++
 tb/tb_apb_uart_tx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_tx.sv
// UART transmitter fed from a TX FIFO head: start bit, 5-8 data bits LSB first,
// optional parity, one or two stop bits. Frame configuration is captured at accept.
module apb_uart_tx #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cfg_en_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic [1:0]           cfg_bits_i,
  input  logic                 cfg_parity_en_i,
  input  logic                 cfg_parity_odd_i,
  input  logic                 cfg_stop2_i,
  input  logic [7:0]           data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] timer_q, timer_d, div_q;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           data_q, data_d;
  logic [1:0]           bits_q;
  logic                 par_en_q, par_q, stop2_q;
  logic                 tx_q, tx_d;
  logic                 accept, tc;
  logic [7:0]           data_mask;

  // ready is gated by reset_n so no pop can be offered while reset is held
  assign ready_o   = reset_n && cfg_en_i && (state_q == IDLE);
  assign accept    = valid_i && ready_o;
  assign tc        = (timer_q == div_q);
  assign data_mask = 8'hFF >> (2'd3 - cfg_bits_i);
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == STOP) && tc && (bit_cnt_q == {2'b00, stop2_q});
  assign tx_o      = tx_q;

  always_comb begin
    state_d   = state_q;
    timer_d   = tc ? '0 : timer_q + DIV_WIDTH'(1);
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    tx_d      = tx_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        tx_d    = 1'b1;
        if (accept) begin
          state_d   = START;
          tx_d      = 1'b0;
          bit_cnt_d = '0;
          data_d    = data_i;
        end
      end
      START: begin
        if (tc) begin
          state_d   = DATA;
          tx_d      = data_q[0];
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        // last data bit index is 4 + bits, i.e. {1, bits}
        if (tc) begin
          if (bit_cnt_q == {1'b1, bits_q}) begin
            state_d   = par_en_q ? PARITY : STOP;
            tx_d      = par_en_q ? par_q : 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            data_d    = data_q >> 1;
            tx_d      = data_q[1];
          end
        end
      end
      PARITY: begin
        if (tc) begin
          state_d   = STOP;
          tx_d      = 1'b1;
          bit_cnt_d = '0;
        end
      end
      STOP: begin
        if (tc) begin
          if (bit_cnt_q == {2'b00, stop2_q}) begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      tx_q      <= 1'b1;
      div_q     <= '0;
      bits_q    <= '0;
      par_en_q  <= 1'b0;
      par_q     <= 1'b0;
      stop2_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
      if (accept) begin
        div_q    <= cfg_div_i;
        bits_q   <= cfg_bits_i;
        par_en_q <= cfg_parity_en_i;
        par_q    <= (^(data_i & data_mask)) ^ cfg_parity_odd_i;
        stop2_q  <= cfg_stop2_i;
      end
    end
  end

endmodule

// File: tb/tb_apb_uart_tx.sv
// Directed bench for apb_uart_tx: hand-computed line patterns checked cycle by cycle,
// back-to-back FIFO drain, mid-frame config change and reset abort.
module tb_apb_uart_tx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_en_i;
  logic [15:0] cfg_div_i;
  logic [1:0]  cfg_bits_i;
  logic        cfg_parity_en_i;
  logic        cfg_parity_odd_i;
  logic        cfg_stop2_i;
  logic [7:0]  data_i;
  logic        valid_i;
  logic        ready_o;
  logic        tx_o;
  logic        busy_o;
  logic        done_o;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  apb_uart_tx #(.DIV_WIDTH(16)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cfg_en_i         (cfg_en_i),
    .cfg_div_i        (cfg_div_i),
    .cfg_bits_i       (cfg_bits_i),
    .cfg_parity_en_i  (cfg_parity_en_i),
    .cfg_parity_odd_i (cfg_parity_odd_i),
    .cfg_stop2_i      (cfg_stop2_i),
    .data_i           (data_i),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .tx_o             (tx_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int div, input logic [1:0] bits, input logic pen,
                               input logic podd, input logic stop2, input logic [7:0] data);
    cfg_div_i        = 16'(div);
    cfg_bits_i       = bits;
    cfg_parity_en_i  = pen;
    cfg_parity_odd_i = podd;
    cfg_stop2_i      = stop2;
    data_i           = data;
    cfg_en_i         = 1'b1;
    valid_i          = 1'b1;
  endtask

  // exp_vec bit i is the i-th bit period on the line; nbits = 1+N+P+S
  task automatic runFrame(input string name, input int div, input logic [1:0] bits,
                          input logic pen, input logic podd, input logic stop2,
                          input logic [7:0] data, input logic [15:0] exp_vec, input int nbits,
                          input int chg_cycle, input logic en_after, input int abort_cycle);
    int total;
    int w;
    total = nbits * (div + 1);
    applyStimulus(div, bits, pen, podd, stop2, data);
    #1;
    w = 0;
    while (!ready_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkOutput({name, "_ready_accept"}, 32'(ready_o), 32'd1);
    @(posedge clk);
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      if (k == 1) valid_i = 1'b0;
      if (k == chg_cycle) begin
        cfg_div_i = 16'd0;
        cfg_en_i  = en_after;
        valid_i   = 1'b1;
      end
      if (k == abort_cycle) begin
        reset_n = 1'b0;
        #1;
        checkOutput({name, "_rst_tx"},    32'(tx_o),    32'd1);
        checkOutput({name, "_rst_busy"},  32'(busy_o),  32'd0);
        checkOutput({name, "_rst_done"},  32'(done_o),  32'd0);
        checkOutput({name, "_rst_ready"}, 32'(ready_o), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int j = 0; j < 45; j++) begin
          @(negedge clk);
          checkOutput($sformatf("%s_post_tx_%0d", name, j),   32'(tx_o),   32'd1);
          checkOutput($sformatf("%s_post_done_%0d", name, j), 32'(done_o), 32'd0);
          checkOutput($sformatf("%s_post_busy_%0d", name, j), 32'(busy_o), 32'd0);
        end
        return;
      end
      checkOutput($sformatf("%s_tx_%0d", name, k),    32'(tx_o),    32'(exp_vec[(k-1)/(div+1)]));
      checkOutput($sformatf("%s_done_%0d", name, k),  32'(done_o),  32'(k == total));
      checkOutput($sformatf("%s_busy_%0d", name, k),  32'(busy_o),  32'd1);
      checkOutput($sformatf("%s_ready_%0d", name, k), 32'(ready_o), 32'd0);
    end
    @(negedge clk);
    checkOutput({name, "_end_tx"},    32'(tx_o),    32'd1);
    checkOutput({name, "_end_busy"},  32'(busy_o),  32'd0);
    checkOutput({name, "_end_done"},  32'(done_o),  32'd0);
    checkOutput({name, "_end_ready"}, 32'(ready_o), 32'(en_after));
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_stay_idle_%0d", name, j), 32'(busy_o), 32'd0);
    end
    valid_i = 1'b0;
  endtask

  logic [7:0] fifo_bytes [3];
  logic       cap [40];

  initial begin
    int idx, xfers, dones;
    logic fire;
    logic [9:0] fv;

    reset_n = 1'b0;
    applyStimulus(3, 2'd3, 1'b0, 1'b0, 1'b0, 8'h55);
    repeat (2) @(negedge clk);
    checkOutput("reset_tx",    32'(tx_o),    32'd1);
    checkOutput("reset_busy",  32'(busy_o),  32'd0);
    checkOutput("reset_done",  32'(done_o),  32'd0);
    checkOutput("reset_ready", 32'(ready_o), 32'd0);
    valid_i = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_ready", 32'(ready_o), 32'd1);

    // div=3 8N1 0x55: 0,1,0,1,0,1,0,1,0,1
    runFrame("f8n1", 3, 2'd3, 1'b0, 1'b0, 1'b0, 8'h55, 16'h02AA, 10, 0, 1'b1, 0);
    // div=0 7E2 0xFF: 0, 1x7, parity 1, 1, 1
    runFrame("f7e2", 0, 2'd2, 1'b1, 1'b0, 1'b1, 8'hFF, 16'h07FE, 11, 0, 1'b1, 0);
    // div=1 5O1 0xE3: 0, 1,1,0,0,0, parity 1, 1
    runFrame("f5o1", 1, 2'd0, 1'b1, 1'b1, 1'b0, 8'hE3, 16'h00C6, 8, 0, 1'b1, 0);

    // three queued bytes, div=0 8N1, valid held high until the FIFO empties
    fifo_bytes[0] = 8'hA5;
    fifo_bytes[1] = 8'h0F;
    fifo_bytes[2] = 8'h3C;
    applyStimulus(0, 2'd3, 1'b0, 1'b0, 1'b0, fifo_bytes[0]);
    valid_i = 1'b0;
    idx = 0;
    xfers = 0;
    dones = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (cyc == 0) valid_i = 1'b1;
      #1;
      cap[cyc] = tx_o;
      if (done_o) dones++;
      fire = valid_i && ready_o;
      if (fire) xfers++;
      @(posedge clk);
      #1;
      if (fire) begin
        idx++;
        if (idx < 3) data_i = fifo_bytes[idx];
        else valid_i = 1'b0;
      end
    end
    checkOutput("b2b_xfers", 32'(xfers), 32'd3);
    checkOutput("b2b_dones", 32'(dones), 32'd3);
    for (int f = 0; f < 3; f++) begin
      fv = {1'b1, fifo_bytes[f], 1'b0};
      for (int j = 0; j < 10; j++)
        checkOutput($sformatf("b2b_f%0d_bit%0d", f, j), 32'(cap[1 + 11*f + j]), 32'(fv[j]));
      checkOutput($sformatf("b2b_gap%0d", f), 32'(cap[11 + 11*f]), 32'd1);
    end
    @(negedge clk);

    // div and enable changed at cycle 6 of a div=3 frame; timing must not change
    runFrame("midchg", 3, 2'd3, 1'b0, 1'b0, 1'b0, 8'h55, 16'h02AA, 10, 6, 1'b0, 0);

    // reset during DATA of an all-zero frame, then a clean frame
    runFrame("abort", 3, 2'd3, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0200, 10, 0, 1'b1, 10);
    runFrame("clean", 3, 2'd3, 1'b0, 1'b0, 1'b0, 8'h55, 16'h02AA, 10, 0, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
